// File: rtl/add4_chk_pkg.sv
// Shared types, default sizes and the reference adder for the add4 result checker.
package add4_chk_pkg;

    localparam int unsigned DEF_WIDTH       = 4;
    localparam int unsigned DEF_NUM_VECTORS = 256;
    localparam int unsigned DEF_CNT_W       = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Golden result: both operands zero-extended so the carry lands in the MSB.
    function automatic logic [DEF_WIDTH:0] add_ref(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b
    );
        return (DEF_WIDTH+1)'(a) + (DEF_WIDTH+1)'(b);
    endfunction

endpackage

// File: rtl/add4_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module add4_chk_sat_cnt
#(
    parameter int unsigned CNT_W = 9
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/add4_result_checker.sv
// Response checker for add4: recomputes a+b for each accepted tuple and keeps run statistics.
// Optional operand-order checking is enabled with `define ADD4_CHK_ORDER_EN.
module add4_result_checker
    import add4_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NUM_VECTORS = DEF_NUM_VECTORS,
    parameter int unsigned CNT_W       = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH:0]   first_fail_exp,
    output logic [WIDTH:0]   first_fail_got,
`ifdef ADD4_CHK_ORDER_EN
    output logic             order_err,
    output logic [CNT_W-1:0] order_err_idx,
`endif
    output logic             all_pass
);

    localparam int unsigned RES_W = WIDTH + 1;
    localparam int unsigned OP_W  = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic             start_go;
    logic             accept;
    logic             last_accept;
    logic             mismatch;
    logic [RES_W-1:0] exp_res;
    logic [RES_W-1:0] got_res;
    logic [CNT_W-1:0] idx_q;
    logic             run_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = RUN;
            RUN:     if (last_accept) state_d = DONE;
            DONE:    if (start)       state_d = RUN;
            default:                  state_d = IDLE;
        endcase
    end

    // State decodes; in_ready depends on state only, never on in_valid
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        start_go = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            IDLE, DONE: start_go = start;
            default: ;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign exp_res     = add_ref(a, b);
    assign got_res     = {carry, sum};
    assign mismatch    = (exp_res != got_res);
    assign last_accept = accept && (idx_q == LAST_IDX);

    // Vector index of the next tuple to be accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (start_go) begin
            idx_q <= '0;
        end else if (accept && (idx_q != '1)) begin
            idx_q <= idx_q + CNT_W'(1);
        end
    end

    add4_chk_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .inc   (accept && !mismatch),
        .cnt   (pass_cnt)
    );

    add4_chk_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .inc   (accept && mismatch),
        .cnt   (fail_cnt)
    );

    // Capture only the first mismatch of a run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (start_go) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (accept && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx_q;
            first_fail_exp <= exp_res;
            first_fail_got <= got_res;
        end
    end

`ifdef ADD4_CHK_ORDER_EN
    logic [OP_W-1:0] exp_ops;
    logic            order_bad;

    assign exp_ops   = OP_W'(idx_q);
    assign order_bad = accept && ({a, b} != exp_ops);

    // Sticky flag plus index of the first out-of-sequence operand pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_err     <= 1'b0;
            order_err_idx <= '0;
        end else if (start_go) begin
            order_err     <= 1'b0;
            order_err_idx <= '0;
        end else if (order_bad && !order_err) begin
            order_err     <= 1'b1;
            order_err_idx <= idx_q;
        end
    end

    assign run_ok = (fail_cnt == '0) && !mismatch && !order_err && !order_bad;
`else
    assign run_ok = (fail_cnt == '0) && !mismatch;
`endif

    // done and all_pass rise together on the edge that takes the final tuple
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done     <= 1'b0;
            all_pass <= 1'b0;
        end else if (start_go) begin
            done     <= 1'b0;
            all_pass <= 1'b0;
        end else if (last_accept) begin
            done     <= 1'b1;
            all_pass <= run_ok;
        end
    end

endmodule

// File: tb/tb_add4_result_checker.sv
// Randomized self-checking bench for add4_result_checker against an arithmetic reference model.
module tb_add4_result_checker;

    localparam int unsigned W   = 4;
    localparam int unsigned NV  = 256;
    localparam int unsigned CW  = 9;
    localparam int          BUDGET = 4000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  sum = '0;
    logic          carry = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          first_fail_vld;
    logic [CW-1:0] first_fail_idx;
    logic [W:0]    first_fail_exp;
    logic [W:0]    first_fail_got;
    logic          all_pass;
`ifdef ADD4_CHK_ORDER_EN
    logic          order_err;
    logic [CW-1:0] order_err_idx;
`endif

    int checks = 0;
    int errors = 0;

    int va [NV];
    int vb [NV];
    int vs [NV];
    int vc [NV];

    add4_result_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .sum            (sum),
        .carry          (carry),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx),
        .first_fail_exp (first_fail_exp),
        .first_fail_got (first_fail_got),
`ifdef ADD4_CHK_ORDER_EN
        .order_err      (order_err),
        .order_err_idx  (order_err_idx),
`endif
        .all_pass       (all_pass)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_sweep();
        for (int i = 0; i < NV; i++) begin
            va[i] = i / 16;
            vb[i] = i % 16;
            vs[i] = (va[i] + vb[i]) % 16;
            vc[i] = (va[i] + vb[i]) / 16;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NV; i++) begin
            va[i] = int'($urandom_range(0, 15));
            vb[i] = int'($urandom_range(0, 15));
            vs[i] = (va[i] + vb[i]) % 16;
            vc[i] = (va[i] + vb[i]) / 16;
        end
    endtask

    task automatic set_result(input int i, input int r);
        vs[i] = r % 16;
        vc[i] = (r / 16) % 2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass_cnt"}, 32'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
        chk({tag, "_ff_vld"}, 32'(first_fail_vld), 0);
        chk({tag, "_ff_idx"}, 32'(first_fail_idx), 0);
        chk({tag, "_ff_exp"}, 32'(first_fail_exp), 0);
        chk({tag, "_ff_got"}, 32'(first_fail_got), 0);
        chk({tag, "_all_pass"}, 32'(all_pass), 0);
`ifdef ADD4_CHK_ORDER_EN
        chk({tag, "_order_err"}, 32'(order_err), 0);
        chk({tag, "_order_err_idx"}, 32'(order_err_idx), 0);
`endif
    endtask

    // gap_mode 0: valid held high, 1: 3 idle cycles every 10 tuples, 2: random gaps.
    // start_at >= 0 raises start while tuple start_at is offered; abort_after >= 0 stops early.
    task automatic do_run(input int gap_mode, input int start_at, input int abort_after);
        int  k, cycles, gap_left, last_gap_k;
        int  mp, mf, fidx, fexp, fgot, oidx, e, g;
        bit  fv, ob, v, ok;
        k = 0; cycles = 0; gap_left = 0; last_gap_k = 0;
        mp = 0; mf = 0; fidx = 0; fexp = 0; fgot = 0; oidx = 0; fv = 0; ob = 0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_pass_clr", 32'(pass_cnt), 0);
        chk("start_fail_clr", 32'(fail_cnt), 0);
        chk("start_done_clr", 32'(done), 0);
        chk("start_ff_clr", 32'(first_fail_vld), 0);

        while (k < NV && cycles < BUDGET) begin
            if (abort_after >= 0 && k == abort_after) break;
            if (gap_mode == 1 && k > 0 && k % 10 == 0 && last_gap_k != k) begin
                gap_left = 3;
                last_gap_k = k;
            end
            if (gap_left > 0) begin
                v = 1'b0;
                gap_left--;
            end else if (gap_mode == 2) begin
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            if (v) begin
                a = W'(va[k]); b = W'(vb[k]); sum = W'(vs[k]); carry = 1'(vc[k]);
            end else begin
                a = W'($urandom); b = W'($urandom); sum = W'($urandom); carry = 1'($urandom);
            end
            in_valid = v;
            start = (k == start_at);
            chk("run_in_ready", 32'(in_ready), 1);
            @(posedge clk); #1;
            cycles++;
            if (v) begin
                e = va[k] + vb[k];
                g = vc[k] * 16 + vs[k];
                if (e == g) begin
                    mp++;
                end else begin
                    mf++;
                    if (!fv) begin
                        fv = 1'b1; fidx = k; fexp = e; fgot = g;
                    end
                end
                if ((va[k] * 16 + vb[k]) != k && !ob) begin
                    ob = 1'b1;
                    oidx = k;
                end
                k++;
                chk("run_pass_cnt", 32'(pass_cnt), 32'(mp));
                chk("run_fail_cnt", 32'(fail_cnt), 32'(mf));
                if (k < NV) chk("run_done_low", 32'(done), 0);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (cycles >= BUDGET) chk("run_timeout", 1, 0);
        if (abort_after >= 0) return;

        ok = (mf == 0);
`ifdef ADD4_CHK_ORDER_EN
        ok = ok && !ob;
        chk("end_order_err", 32'(order_err), 32'(ob));
        chk("end_order_err_idx", 32'(order_err_idx), ob ? 32'(oidx) : 0);
`endif
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_in_ready", 32'(in_ready), 0);
        chk("end_pass_cnt", 32'(pass_cnt), 32'(mp));
        chk("end_fail_cnt", 32'(fail_cnt), 32'(mf));
        chk("end_all_pass", 32'(all_pass), 32'(ok));
        chk("end_ff_vld", 32'(first_fail_vld), 32'(fv));
        chk("end_ff_idx", 32'(first_fail_idx), fv ? 32'(fidx) : 0);
        chk("end_ff_exp", 32'(first_fail_exp), fv ? 32'(fexp) : 0);
        chk("end_ff_got", 32'(first_fail_got), fv ? 32'(fgot) : 0);

        // Tuples offered after completion must be ignored
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); sum = W'($urandom); carry = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("post_done_pass", 32'(pass_cnt), 32'(mp));
        chk("post_done_fail", 32'(fail_cnt), 32'(mf));
        chk("post_done_hold", 32'(done), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", 32'(busy), 0);

        // Exhaustive correct sweep, valid held high
        fill_sweep();
        do_run(0, -1, -1);
        chk("sweep_pass_256", 32'(pass_cnt), 256);
        chk("sweep_all_pass", 32'(all_pass), 1);

        // Injected faults at idx 37 and 200
        fill_sweep();
        set_result(37, 6);
        set_result(200, 21);
        do_run(0, -1, -1);
        chk("fault_fail_cnt", 32'(fail_cnt), 2);
        chk("fault_ff_idx", 32'(first_fail_idx), 37);
        chk("fault_ff_exp", 32'(first_fail_exp), 32'h07);
        chk("fault_ff_got", 32'(first_fail_got), 32'h06);
        chk("fault_all_pass", 32'(all_pass), 0);

        // Carry boundary a=F,b=1 answered with 0, plus start on the final acceptance
        fill_sweep();
        set_result(241, 0);
        do_run(0, NV - 1, -1);
        chk("carry_fail_cnt", 32'(fail_cnt), 1);
        chk("carry_ff_idx", 32'(first_fail_idx), 241);
        chk("carry_ff_exp", 32'(first_fail_exp), 32'h10);
        chk("carry_ff_got", 32'(first_fail_got), 32'h00);

        // Gapped handshake with a start pulse mid-run
        fill_sweep();
        do_run(1, 50, -1);
        chk("gap_pass_256", 32'(pass_cnt), 256);

        // Random operands, random faults, random valid gaps
        for (int r = 0; r < 4; r++) begin
            int nf, idx, e;
            fill_random();
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) begin
                idx = int'($urandom_range(0, NV - 1));
                e = va[idx] + vb[idx];
                set_result(idx, (e + int'($urandom_range(1, 31))) % 32);
            end
            do_run(2, -1, -1);
        end

        // Reset after 100 accepts, then a clean full sweep
        fill_sweep();
        do_run(0, -1, 100);
        chk("abort_pass_100", 32'(pass_cnt), 100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_zero("midrun_reset");
        fill_sweep();
        do_run(0, -1, -1);
        chk("after_reset_pass_256", 32'(pass_cnt), 256);

`ifdef ADD4_CHK_ORDER_EN
        // Tuples 10 and 11 swapped: sums stay correct, order is violated
        fill_sweep();
        begin
            int t;
            t = va[10]; va[10] = va[11]; va[11] = t;
            t = vb[10]; vb[10] = vb[11]; vb[11] = t;
            t = vs[10]; vs[10] = vs[11]; vs[11] = t;
            t = vc[10]; vc[10] = vc[11]; vc[11] = t;
        end
        do_run(0, -1, -1);
        chk("order_flag", 32'(order_err), 1);
        chk("order_idx", 32'(order_err_idx), 10);
        chk("order_all_pass", 32'(all_pass), 0);
        chk("order_fail_cnt", 32'(fail_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add4_result_checker.md
Name: add4_result_checker

Overview:
- Hardware response checker for the 4-bit adder (`add4`); it sits on the result side of the adder's operand/result interface.
- Consumes {a, b, sum, carry} tuples through a valid/ready handshake and recomputes the expected result.
- Keeps pass/fail counters, captures the first mismatch, and signals completion after an exhaustive sweep.
- Used to self-check `add4` on-chip or in regression, so no waveform inspection is needed.

Parameters:
- WIDTH, 4, operand width of a, b and sum.
- NUM_VECTORS, 256, vectors per run; must be ≤ 2^(2*WIDTH).
- CNT_W, 9, width of the pass/fail counters and the index fields; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run (IDLE or DONE only).
- in_valid  in  1  tuple present on a/b/sum/carry.
- in_ready  out  1  checker accepts a tuple this cycle.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- sum  in  WIDTH  DUT sum.
- carry  in  1  DUT carry-out.
- busy  out  1  state is RUN.
- done  out  1  run complete; held until the next start or reset.
- pass_cnt  out  CNT_W  matching tuples in this run.
- fail_cnt  out  CNT_W  mismatching tuples in this run.
- first_fail_vld  out  1  first_fail_* fields are valid.
- first_fail_idx  out  CNT_W  vector index of the first mismatch.
- first_fail_exp  out  WIDTH+1  expected {carry,sum} at the first mismatch.
- first_fail_got  out  WIDTH+1  received {carry,sum} at the first mismatch.
- all_pass  out  1  done && fail_cnt==0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - All counters, indices and first_fail_* fields are 0.
  - busy, done, first_fail_vld, all_pass and in_ready are 0.
  - Reset mid-run aborts the run; no partial result is preserved.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the accepted count reaches NUM_VECTORS; the transition happens on the same edge as the last acceptance.
  - DONE→RUN on start.
  - start in RUN is ignored.
- Entering RUN: pass_cnt, fail_cnt, idx, first_fail_* and done all clear on the start edge.
- in_ready = (state==RUN); it is a registered-state decode only and has no combinational path from in_valid.
- Acceptance: a tuple is accepted when in_valid && in_ready at a clk edge.
  - The tuple is checked in that same cycle; the counter update is visible one cycle later (latency 1).
- Expected result = zero-extended a + zero-extended b, computed at WIDTH+1 bits.
  - Compared against {carry,sum}.
  - Wrap example: a=4'hF, b=4'h1 → expected 5'b1_0000.
- Match: pass_cnt++. Mismatch: fail_cnt++.
  - On the first mismatch of a run only: set first_fail_vld and latch idx, expected and received.
  - Later mismatches do not overwrite the first_fail_* fields.
- idx increments on every acceptance and starts from 0 each run.
  - The final acceptance is idx = NUM_VECTORS-1.
- Counters saturate at all-ones. This is unreachable with legal parameters but still required.
- in_valid outside RUN is ignored, and the inputs are don't-care.
- start in the same cycle as the final acceptance: the final tuple is counted, then state goes to DONE.
  - That start is ignored because it arrives while in RUN.
- done and all_pass are registered and rise one cycle after the final acceptance.

Optional Feature:
- Macro: ADD4_CHK_ORDER_EN.
- Defined:
  - The checker also requires {a,b} == idx[2*WIDTH-1:0] on every accepted tuple, i.e. an exhaustive ascending sweep.
  - Adds output order_err (1 bit), a sticky flag cleared on reset or start.
  - Adds output order_err_idx (CNT_W), the idx of the first out-of-order tuple.
  - An out-of-order tuple still goes through the sum check as normal.
  - all_pass additionally requires !order_err.
- Undefined:
  - The order_err and order_err_idx ports are absent.
  - Operand order is unconstrained.

Decomposition:
- Shared package add4_chk_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default WIDTH;
  - the NUM_VECTORS default constant;
  - a function add_ref(a,b) returning the WIDTH+1 result.
- One natural sub-module: add4_chk_sat_cnt, a saturating CNT_W counter with clear and inc inputs.
  - Instantiated twice, for pass and fail.

Test Plan:
- Exhaustive sweep:
  - Stimulus: reset, start, then 256 correct tuples with {a,b}=0..255 and in_valid held high.
  - Response: pass_cnt=256, fail_cnt=0, done=1 and all_pass=1 one cycle after the last accept; first_fail_vld=0.
- Injected faults:
  - Stimulus: sweep where idx 37 (a=2,b=5) sends sum=4'h6, and idx 200 also sends a wrong result.
  - Response: fail_cnt=2, first_fail_idx=37, first_fail_exp=5'h07, first_fail_got=5'h06, all_pass=0.
- Carry boundary:
  - Stimulus: a=F,b=1 with carry=0,sum=0.
  - Response: counted as a fail; exp=5'h10, got=5'h00.
- Gapped handshake and illegal start:
  - Stimulus: deassert in_valid for 3 cycles every 10 tuples; pulse start mid-run.
  - Response: the run is unaffected; done only after 256 accepts.
- Reset mid-run:
  - Stimulus: rst_n low after 100 accepts.
  - Response: all outputs 0 and state IDLE.
  - A subsequent start with a full correct sweep gives pass_cnt=256.
- Order check (with ADD4_CHK_ORDER_EN defined):
  - Stimulus: tuples 10 and 11 swapped.
  - Response: order_err=1, order_err_idx=10, all_pass=0, fail_cnt=0.
